// File: rtl/adder_bcd_serial.sv
// Digit-serial multi-digit BCD adder: one digit per clock, LSD first, registered decimal carry.
// Optional ten's-complement subtraction is enabled by defining ADDER_BCD_SUB_EN.
module adder_bcd_serial #(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       in0,
  input  logic [4*DIGITS-1:0]       in1,
`ifdef ADDER_BCD_SUB_EN
  input  logic                      sub,
`endif
  output logic [4*(DIGITS+1)-1:0]   out,
  output logic                      flag,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  res_sr;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          err;
`ifdef ADDER_BCD_SUB_EN
  logic          sub_q;
`endif

  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    b_eff;
  logic [4:0]    s;
  logic [3:0]    digit;
  logic          carry_nx;
  logic          err_nx;
  logic [W-1:0]  res_nx;
  logic [3:0]    top_dig;

  // One decimal digit step; the invalid-digit check looks at the original operand digits.
  always_comb begin
    a_dig = a_sr[3:0];
    b_dig = b_sr[3:0];
`ifdef ADDER_BCD_SUB_EN
    b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
`else
    b_eff = b_dig;
`endif
    s = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
    if (s > 5'd9) begin
      digit    = 4'(s + 5'd6);
      carry_nx = 1'b1;
    end else begin
      digit    = s[3:0];
      carry_nx = 1'b0;
    end
    err_nx = err | (a_dig > 4'd9) | (b_dig > 4'd9);
    res_nx = (res_sr >> 4) | (W'(digit) << (W - 4));
`ifdef ADDER_BCD_SUB_EN
    if (sub_q)
      top_dig = carry_nx ? 4'd0 : 4'd9;
    else
      top_dig = {3'b000, carry_nx};
`else
    top_dig = {3'b000, carry_nx};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
`ifdef ADDER_BCD_SUB_EN
      sub_q  <= 1'b0;
`endif
      out    <= '0;
      flag   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= in0;
            b_sr   <= in1;
            res_sr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
`ifdef ADDER_BCD_SUB_EN
            sub_q  <= sub;
            carry  <= sub;
`else
            carry  <= 1'b0;
`endif
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          res_sr <= res_nx;
          carry  <= carry_nx;
          err    <= err_nx;
          if (cnt == LAST) begin
            out   <= err_nx ? '0 : {top_dig, res_nx};
            flag  <= err_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bcd_serial.sv
// Self-checking bench for adder_bcd_serial (DIGITS=4): vector table plus hand-written
// back-to-back, ignored-start, mid-operation reset and (with ADDER_BCD_SUB_EN) subtract cases.
module tb_adder_bcd_serial;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        sub;
  logic [19:0] out;
  logic        flag;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sb;
    logic [19:0] exp_out;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[$];

  adder_bcd_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in0   (in0),
    .in1   (in1),
`ifdef ADDER_BCD_SUB_EN
    .sub   (sub),
`endif
    .out   (out),
    .flag  (flag),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulses start for one edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sb);
    in0   = a;
    in1   = b;
    sub   = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the start edge until done is seen (bounded).
  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    int npulse;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    in0    = '0;
    in1    = '0;
    sub    = 1'b0;

    vecs.push_back('{16'h1234, 16'h8766, 1'b0, 20'h10000, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b0, 20'h19998, 1'b0});
    vecs.push_back('{16'h0000, 16'h0001, 1'b0, 20'h00001, 1'b0});
    vecs.push_back('{16'h4567, 16'h1111, 1'b0, 20'h05678, 1'b0});
    vecs.push_back('{16'h0999, 16'h0001, 1'b0, 20'h01000, 1'b0});
    vecs.push_back('{16'h5000, 16'h5000, 1'b0, 20'h10000, 1'b0});
    vecs.push_back('{16'h00A0, 16'h0001, 1'b0, 20'h00000, 1'b1});
    vecs.push_back('{16'h0000, 16'h000F, 1'b0, 20'h00000, 1'b1});
    vecs.push_back('{16'h0005, 16'h0005, 1'b0, 20'h00010, 1'b0});
`ifdef ADDER_BCD_SUB_EN
    vecs.push_back('{16'h0010, 16'h0005, 1'b1, 20'h00005, 1'b0});
    vecs.push_back('{16'h0005, 16'h0010, 1'b1, 20'h99995, 1'b0});
`endif

    #12;
    checkOutput("reset_out",  32'(out),  32'h0);
    checkOutput("reset_flag", 32'(flag), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sb);
      checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      waitDone(cyc);
      checkOutput($sformatf("v%0d_latency", i), 32'(cyc), 32'(DIGITS));
      checkOutput($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      checkOutput($sformatf("v%0d_flag", i), 32'(flag), 32'(vecs[i].exp_flag));
      checkOutput($sformatf("v%0d_busy_done", i), 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_done_width", i), 32'(done), 32'h0);
    end

    // Back-to-back: new start issued in the done cycle.
    applyStimulus(16'h9999, 16'h9999, 1'b0);
    waitDone(cyc);
    checkOutput("b2b_first_out", 32'(out), 32'h19998);
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    waitDone(cyc);
    checkOutput("b2b_second_latency", 32'(cyc), 32'(DIGITS));
    checkOutput("b2b_second_out", 32'(out), 32'h00001);
    @(posedge clk);
    #1;

    // Start while busy is ignored; operand changes mid-operation have no effect.
    applyStimulus(16'h1234, 16'h8766, 1'b0);
    npulse = 0;
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) begin
        in0 = 16'h5555; in1 = 16'h1111; start = 1'b1;
      end else if (i == 2) begin
        start = 1'b0;
      end else if (i == 3) begin
        in0 = 16'h9999;
      end
      @(posedge clk);
      #1;
      if (done) begin
        npulse++;
        if (cyc == 0) cyc = i;
        checkOutput("ignore_out", 32'(out), 32'h10000);
      end
    end
    start = 1'b0;
    checkOutput("ignore_pulses", 32'(npulse), 32'h1);
    checkOutput("ignore_latency", 32'(cyc), 32'(DIGITS));

    // Asynchronous reset two cycles into an operation.
    applyStimulus(16'h4567, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out",  32'(out),  32'h0);
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    checkOutput("rst_mid_done", 32'(done), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) npulse++;
    end
    checkOutput("rst_no_done", 32'(npulse), 32'h0);
    checkOutput("rst_out_held", 32'(out), 32'h0);
    applyStimulus(16'h0005, 16'h0005, 1'b0);
    waitDone(cyc);
    checkOutput("rst_fresh_out", 32'(out), 32'h00010);
    checkOutput("rst_fresh_flag", 32'(flag), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bcd_serial.md
# adder_bcd_serial

Parametrised, digit-serial multi-digit BCD adder; the sequential successor of the single-digit combinational BCD adder. It latches two packed BCD operands of DIGITS digits on a start strobe. It then adds one digit per clock, least significant first, with a registered decimal carry, and presents a DIGITS+1 digit result with a one-cycle done pulse and an invalid-digit flag. It sits between operand registers and display/accumulator logic where wide BCD sums are needed without a wide combinational carry chain.

## Interface
- DIGITS, 4 — number of BCD digits per operand; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- in0  input  4*DIGITS  packed BCD operand A; digit k in bits [4k+3:4k].
- in1  input  4*DIGITS  packed BCD operand B; same packing.
- sub  input  1  present only with ADDER_BCD_SUB_EN; 1 = A−B, sampled with start.
- out  output  4*(DIGITS+1)  packed BCD result; top digit holds the final carry, or sign digit in subtract mode.
- flag  output  1  error: at least one operand digit was >9.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: out/flag just updated.

## Operation
- States: IDLE, ADD. Reset → IDLE; out=0, flag=0, busy=0, done=0, digit counter=0, carry=0.
- IDLE with start=1:
  - latch in0, in1 (and sub) into shift registers;
  - clear carry and counter; set carry=1 in subtract mode;
  - go to ADD.
- ADD, each cycle, on the current low digits a, b:
  - s = a + b + carry (5-bit);
  - if s>9: digit = s+6 (low 4 bits), carry=1; else digit = s, carry=0;
  - shift the digit into the result register;
  - if a>9 or b>9, set a sticky error bit;
  - increment the counter.
- After the digit with counter = DIGITS−1:
  - load out = {carry digit (0 or 1), DIGITS result digits}, zero-extended to 4 bits;
  - flag = sticky error;
  - pulse done;
  - return to IDLE.
- Error: if the sticky error bit is set, out is loaded as all zeros and flag=1. Otherwise flag=0.
- out and flag hold their values until the next completed operation. They are not cleared on start.
- start while busy=1 is ignored; it is neither queued nor does it restart the operation.
- Counter width is max(1,$clog2(DIGITS)) bits and never wraps past DIGITS−1.

## Timing
- start sampled high at edge t0 → busy=1 from t0 until edge t0+DIGITS. At t0+DIGITS: out/flag update, done=1 for exactly one cycle, busy=0.
- Latency start→done is DIGITS cycles. Throughput is one operation per DIGITS cycles.
- In the done cycle the block is IDLE, so a start there is accepted at the next edge (back-to-back operation).
- Operands need only be valid at the start edge; later changes to in0/in1 have no effect.
- rst_n low at any time, including mid-operation, immediately forces all outputs and state to their reset values. The partial result is discarded and no done pulse is issued.

## Configuration
- ADDER_BCD_SUB_EN defined:
  - adds the sub port;
  - sub=1 replaces each in1 digit b with 9−b and sets the initial carry to 1 (ten's complement);
  - the top out digit is 0 if the final carry is 1 (non-negative), else 9 (negative, ten's-complement result);
  - the invalid-digit check applies to the original in1 digits.
- Not defined: no sub port; addition only; behaviour as above.

## Test plan
- DIGITS=4, in0=0x1234, in1=0x8766, start 1 cycle → done exactly 4 cycles later, out=0x10000, flag=0.
- in0=0x9999, in1=0x9999 → out=0x19998, flag=0. Then a back-to-back start in the done cycle with 0x0000+0x0001 → out=0x00001 after 4 more cycles.
- in0=0x00A0, in1=0x0001 → flag=1, out=0x00000, done pulses normally.
- start pulsed again while busy=1 → ignored; exactly one done pulse; result matches the first operands. Also, changing in0 mid-operation does not alter out.
- rst_n low 2 cycles into an operation → out=0, busy=0, done never pulses. A fresh 0x0005+0x0005 then gives out=0x00010.
- With ADDER_BCD_SUB_EN: 0x0010−0x0005 → out=0x00005; 0x0005−0x0010 → out=0x99995; flag=0 for both.
